// File: rtl/icosoc_dbgdump_uart_pkg.sv
// icosoc_dbgdump_uart_pkg: ASCII constants, hex encoder and formatter states.
// Rev 1.0
`default_nettype none

package icosoc_dbgdump_uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    FMT_IDLE = 3'd0,
    FMT_HI   = 3'd1,
    FMT_LO   = 3'd2,
    FMT_CR   = 3'd3,
    FMT_LF   = 3'd4
  } fmt_state_t;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

`default_nettype wire

// File: rtl/icosoc_dbgdump_uart_if.sv
// icosoc_dbgdump_uart_if: byte-serial dump stream (valid/ready/data).
// Rev 1.0
`default_nettype none

interface icosoc_dbgdump_uart_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/icosoc_dbgdump_uart_tx8n1.sv
// icosoc_uart_tx8n1: 8N1 LSB-first UART transmitter with registered output.
// Rev 1.0
`default_nettype none

module icosoc_uart_tx8n1 #(
  parameter int CLKDIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx
);

  localparam int            CW        = $clog2(CLKDIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift_reg;
  logic          active;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  // Ready during the final stop-bit cycle so the next frame follows seamlessly.
  assign tx_ready  = !active || frame_end;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= 4'd0;
      shift_reg <= '1;
      tx        <= 1'b1;
    end else begin
      tx <= active ? shift_reg[0] : 1'b1;
      if (tx_valid && tx_ready) begin
        active    <= 1'b1;
        shift_reg <= {1'b1, tx_data, 1'b0};
        baud_cnt  <= '0;
        bit_cnt   <= 4'd0;
      end else if (active) begin
        if (bit_end) begin
          baud_cnt  <= '0;
          shift_reg <= {1'b1, shift_reg[9:1]};
          bit_cnt   <= bit_cnt + 4'd1;
          if (frame_end) begin
            active <= 1'b0;
          end
        end else begin
          baud_cnt <= baud_cnt + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icosoc_dbgdump_uart.sv
// icosoc_dbgdump_uart: dump bytes -> uppercase hex text with CR LF -> UART TX.
// Rev 1.0
`default_nettype none

module icosoc_dbgdump_uart
  import icosoc_dbgdump_uart_pkg::*;
#(
  parameter int BYTES_PER_LINE = 4,
  parameter int CLKDIV         = 104
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 dump_en,
  icosoc_dbgdump_uart_if.slave dump,
  output logic                 uart_tx,
  output logic                 busy
);

  localparam logic [7:0] LINE_LAST = 8'(BYTES_PER_LINE - 1);

  fmt_state_t state, state_nxt;
  logic [7:0] data_q;
  logic [7:0] line_cnt, line_nxt;
  logic       run;
  logic [1:0] tail;
  logic       accept;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  assign accept = dump.in_valid && dump.in_ready;
  // tail covers the output register lag and the last stop-bit cycle on the line.
  assign busy   = (state != FMT_IDLE) || !tx_ready || (tail != 2'b00);

  always_comb begin
    state_nxt     = state;
    line_nxt      = line_cnt;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    dump.in_ready = 1'b0;
    case (state)
      FMT_IDLE: begin
        dump.in_ready = run && tx_ready;
        if (dump.in_valid && run && tx_ready) state_nxt = FMT_HI;
      end
      FMT_HI: begin
        tx_valid = 1'b1;
        tx_data  = hex_ascii(data_q[7:4]);
        if (tx_ready) state_nxt = FMT_LO;
      end
      FMT_LO: begin
        tx_valid = 1'b1;
        tx_data  = hex_ascii(data_q[3:0]);
        if (tx_ready) begin
          if (line_cnt == LINE_LAST) begin
            line_nxt  = 8'd0;
            state_nxt = FMT_CR;
          end else begin
            line_nxt  = line_cnt + 8'd1;
            state_nxt = FMT_IDLE;
          end
        end
      end
      FMT_CR: begin
        tx_valid = 1'b1;
        tx_data  = CHAR_CR;
        if (tx_ready) state_nxt = FMT_LF;
      end
      FMT_LF: begin
        tx_valid = 1'b1;
        tx_data  = CHAR_LF;
        if (tx_ready) state_nxt = FMT_IDLE;
      end
      default: state_nxt = FMT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= FMT_IDLE;
      line_cnt <= 8'd0;
      data_q   <= 8'd0;
      run      <= 1'b0;
      tail     <= 2'b00;
      dump_en  <= 1'b0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_nxt;
      run      <= 1'b1;
      tail     <= {tail[0], !tx_ready};
      if (accept) data_q <= dump.in_data;
      if (dump_en) begin
        if (accept) dump_en <= 1'b0;
      end else if (start) begin
        dump_en <= 1'b1;
      end
    end
  end

  icosoc_uart_tx8n1 #(
    .CLKDIV (CLKDIV)
  ) u_tx (
    .clk      (clk),
    .resetn   (resetn),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx       (uart_tx)
  );

endmodule

`default_nettype wire
